// File: rtl/score_keeper.sv
// Multi-player saturating score keeper with IDLE/PLAYING/OVER phases, session high score and leader/tie.
// Optional combo scoring (+2 inside a per-player window) is built when SCORE_COMBO_EN is defined.

module score_lane #(
  parameter int SCORE_W      = 6,
  parameter int COMBO_WINDOW = 50_000_000
) (
  input  logic               clkIn,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_en,
  input  logic               i_evt,
  output logic [SCORE_W-1:0] o_score
);
  localparam logic [SCORE_W-1:0] SMAX = '1;

  logic [SCORE_W-1:0] r_score;
  logic [1:0]         w_inc;
  logic [SCORE_W:0]   w_sum;
  logic [SCORE_W-1:0] w_next;

`ifdef SCORE_COMBO_EN
  localparam int CW = $clog2(COMBO_WINDOW);
  logic [CW-1:0] r_combo;

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset)                 r_combo <= '0;
    else if (i_clear)          r_combo <= '0;
    else if (i_en) begin
      if (i_evt)               r_combo <= CW'(COMBO_WINDOW - 1);
      else if (r_combo != '0)  r_combo <= r_combo - 1'b1;
    end
  end

  assign w_inc = (r_combo != '0) ? 2'd2 : 2'd1;
`else
  assign w_inc = 2'd1;
`endif

  // one spare bit catches overflow so the score clamps instead of wrapping
  assign w_sum  = {1'b0, r_score} + (SCORE_W+1)'(w_inc);
  assign w_next = w_sum[SCORE_W] ? SMAX : w_sum[SCORE_W-1:0];

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset)              r_score <= '0;
    else if (i_clear)       r_score <= '0;
    else if (i_en && i_evt) r_score <= w_next;
  end

  assign o_score = r_score;
endmodule

module score_keeper #(
  parameter  int NUM_PLAYERS  = 2,
  parameter  int SCORE_W      = 6,
  parameter  int COMBO_WINDOW = 50_000_000,
  localparam int LEAD_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clkIn,
  input  logic                           reset,
  input  logic                           gameStart,
  input  logic                           timer_expired,
  input  logic [NUM_PLAYERS-1:0]         player_scored,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [SCORE_W-1:0]             high_score,
  output logic [LEAD_W-1:0]              leader,
  output logic                           tie,
  output logic                           game_active,
  output logic                           game_over
);
  typedef enum logic [1:0] {IDLE, PLAYING, OVER} state_t;

  state_t r_state, w_next;
  logic   r_arm, r_start_q, r_timer_q;
  logic   [NUM_PLAYERS-1:0] r_ps_q;
  logic   w_start_rise, w_timer_rise, w_clear, w_end;
  logic   [NUM_PLAYERS-1:0] w_ps_rise;
  logic   [NUM_PLAYERS-1:0][SCORE_W-1:0] w_score;
  logic   [SCORE_W-1:0] w_max, r_high;
  logic   [LEAD_W-1:0]  w_leader, r_leader;
  logic   [3:0]         w_cnt;
  logic   w_tie, r_tie;

  // r_arm masks the first cycle after reset so a level already high is not seen as an edge
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      r_arm     <= 1'b0;
      r_start_q <= 1'b0;
      r_timer_q <= 1'b0;
      r_ps_q    <= '0;
    end else begin
      r_arm     <= 1'b1;
      r_start_q <= gameStart;
      r_timer_q <= timer_expired;
      r_ps_q    <= player_scored;
    end
  end

  assign w_start_rise = r_arm & gameStart & ~r_start_q;
  assign w_timer_rise = r_arm & timer_expired & ~r_timer_q;
  assign w_ps_rise    = {NUM_PLAYERS{r_arm}} & player_scored & ~r_ps_q;
  assign w_clear      = w_start_rise;

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_rise) w_next = PLAYING;
      PLAYING: if (w_start_rise) w_next = PLAYING;
               else if (w_timer_rise) w_next = OVER;
      OVER:    if (w_start_rise) w_next = PLAYING;
      default: w_next = IDLE;
    endcase
  end

  assign w_end       = (r_state == PLAYING) && (w_next == OVER);
  assign game_active = (r_state == PLAYING);
  assign game_over   = (r_state == OVER);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
    score_lane #(.SCORE_W(SCORE_W), .COMBO_WINDOW(COMBO_WINDOW)) u_lane (
      .clkIn   (clkIn),
      .reset   (reset),
      .i_clear (w_clear),
      .i_en    (r_state == PLAYING),
      .i_evt   (w_ps_rise[p]),
      .o_score (w_score[p])
    );
  end

  // strict '>' keeps the lowest index on ties
  always_comb begin
    w_max    = w_score[0];
    w_leader = '0;
    w_cnt    = '0;
    for (int p = 1; p < NUM_PLAYERS; p++)
      if (w_score[p] > w_max) begin
        w_max    = w_score[p];
        w_leader = LEAD_W'(p);
      end
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (w_score[p] == w_max) w_cnt = w_cnt + 4'd1;
    w_tie = (w_cnt > 4'd1);
  end

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      r_leader <= '0;
      r_tie    <= 1'b1;
      r_high   <= '0;
    end else begin
      if (w_clear) begin
        r_leader <= '0;
        r_tie    <= 1'b1;
      end else begin
        r_leader <= w_leader;
        r_tie    <= w_tie;
      end
      if (w_end && (w_max > r_high)) r_high <= w_max;
    end
  end

  assign score      = w_score;
  assign high_score = r_high;
  assign leader     = r_leader;
  assign tie        = r_tie;
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with 2 players, 3-bit scores and a 10-cycle combo window.
module tb_score_keeper;
  localparam int NP = 2;
  localparam int SW = 3;
`ifdef SCORE_COMBO_EN
  localparam int C5 = 3, C20 = 4;
`else
  localparam int C5 = 2, C20 = 3;
`endif

  logic             clkIn = 1'b0;
  logic             reset, gameStart, timer_expired;
  logic [NP-1:0]    player_scored;
  logic [NP*SW-1:0] score;
  logic [SW-1:0]    high_score;
  logic [0:0]       leader;
  logic             tie, game_active, game_over;
  int n_chk = 0, n_bad = 0;

  always #5 clkIn = ~clkIn;

  score_keeper #(.NUM_PLAYERS(NP), .SCORE_W(SW), .COMBO_WINDOW(10)) dut (
    .clkIn(clkIn), .reset(reset), .gameStart(gameStart), .timer_expired(timer_expired),
    .player_scored(player_scored), .score(score), .high_score(high_score),
    .leader(leader), .tie(tie), .game_active(game_active), .game_over(game_over)
  );

  task chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  function int sc(input int p);
    return int'(score[p*SW +: SW]);
  endfunction

  task step();
    @(posedge clkIn); #1;
  endtask

  task idle(input int n);
    repeat (n) step();
  endtask

  // spacing of 12 cycles lets any combo window expire between events
  task pulse(input logic [NP-1:0] m);
    player_scored = m; step();
    player_scored = '0; idle(11);
  endtask

  task start_game();
    gameStart = 1'b1; step();
    gameStart = 1'b0; step();
  endtask

  task end_game();
    timer_expired = 1'b1; step();
    timer_expired = 1'b0; step();
  endtask

  initial begin
    reset = 1'b1; gameStart = 1'b0; timer_expired = 1'b0; player_scored = '0;
    idle(2);
    chk("rst_p0", sc(0), 0);       chk("rst_p1", sc(1), 0);
    chk("rst_high", high_score, 0); chk("rst_leader", leader, 0);
    chk("rst_tie", tie, 1);        chk("rst_active", game_active, 0);
    chk("rst_over", game_over, 0);
    reset = 1'b0; step();

    start_game();
    chk("start_active", game_active, 1); chk("start_tie", tie, 1);
    player_scored = 2'b01; step();
    chk("first_p0", sc(0), 1); chk("tie_lag", tie, 1);
    player_scored = '0; step();
    chk("tie_after", tie, 0); chk("leader_after", leader, 0);
    idle(10);
    pulse(2'b01); pulse(2'b01);
    chk("three_p0", sc(0), 3); chk("three_tie", tie, 0);

    pulse(2'b11);
    chk("both_p0", sc(0), 4); chk("both_p1", sc(1), 1);
    repeat (10) pulse(2'b10);
    chk("sat_p1", sc(1), 7); chk("sat_leader", leader, 1);

    gameStart = 1'b1; step();
    chk("restart_p0", sc(0), 0); chk("restart_p1", sc(1), 0);
    chk("restart_leader", leader, 0); chk("restart_tie", tie, 1);
    gameStart = 1'b0; step();

    player_scored = 2'b01; step(); chk("combo_0", sc(0), 1);
    player_scored = '0; idle(4);
    player_scored = 2'b01; step(); chk("combo_5", sc(0), C5);
    player_scored = '0; idle(14);
    player_scored = 2'b01; step(); chk("combo_20", sc(0), C20);
    player_scored = '0; idle(11);

    gameStart = 1'b1; timer_expired = 1'b1; step();
    chk("both_edge_active", game_active, 1); chk("both_edge_over", game_over, 0);
    chk("both_edge_p0", sc(0), 0);           chk("both_edge_high", high_score, 0);
    gameStart = 1'b0; timer_expired = 1'b0; step();

    pulse(2'b01);
    chk("pre_rst_p0", sc(0), 1);
    reset = 1'b1; gameStart = 1'b1; #1;
    chk("async_p0", sc(0), 0); chk("async_tie", tie, 1); chk("async_active", game_active, 0);
    idle(2);
    reset = 1'b0; idle(3);
    chk("held_start", game_active, 0);
    gameStart = 1'b0; step();
    start_game();
    chk("g1_active", game_active, 1);
    repeat (5) pulse(2'b01);
    chk("g1_p0", sc(0), 5);
    end_game();
    chk("g1_over", game_over, 1); chk("g1_active_off", game_active, 0);
    chk("g1_high", high_score, 5);
    pulse(2'b01);
    chk("over_hold", sc(0), 5);

    player_scored = 2'b01; step();
    gameStart = 1'b1; player_scored = 2'b11; step();
    chk("g2_active", game_active, 1); chk("g2_clr_p0", sc(0), 0); chk("g2_high", high_score, 5);
    gameStart = 1'b0; idle(2);
    chk("held_p0", sc(0), 0); chk("discard_p1", sc(1), 0);
    player_scored = '0; step();
    player_scored = 2'b01; step();
    chk("rearm_p0", sc(0), 1);
    player_scored = '0; idle(11);
    pulse(2'b01); pulse(2'b01);
    chk("g2_p0", sc(0), 3);
    end_game();
    chk("g2_over", game_over, 1); chk("g2_high_kept", high_score, 5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
